// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin, burst-limited arbiter sharing one single-port memory between CPU (C) and debug (D)
// Ports:
//   clk, rst (async, active-low)
//   c_req/c_we/c_addr/c_wdata -> c_gnt (comb), c_rvalid/c_rdata : CPU requester
//   d_req/d_we/d_addr/d_wdata -> d_gnt (comb), d_rvalid/d_rdata : debug requester
//   mem_addr/mem_din/mem_ena/mem_wea -> memory, mem_dout <- memory
//   owner : registered owner, 0 IDLE, 1 C, 2 D
module mem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_ena,
    output logic          mem_wea,
    input  logic [DW-1:0] mem_dout,
    output logic [1:0]    owner
);
    typedef enum logic [1:0] {IDLE = 2'd0, OWN_C = 2'd1, OWN_D = 2'd2} owner_t;
    localparam logic [3:0] MB = 4'(MAX_BURST);
    owner_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [RD_LAT-1:0] tv, tid;
    logic              rv, rid;
    always_comb begin
        c_gnt    = 1'b0;
        d_gnt    = 1'b0;
        state_nx = IDLE;
        cnt_nx   = 4'd0;
        if (rst) begin
            // C wins when alone, from IDLE, while under its burst limit, or when D's burst is exhausted
            if (c_req && (!d_req || state == IDLE || (state == OWN_C ? cnt < MB : cnt >= MB)))
                c_gnt = 1'b1;
            else if (d_req)
                d_gnt = 1'b1;
            if (c_gnt) begin
                state_nx = OWN_C;
                cnt_nx   = (state == OWN_C) ? ((cnt < MB) ? cnt + 4'd1 : MB) : 4'd1;
            end
            if (d_gnt) begin
                state_nx = OWN_D;
                cnt_nx   = (state == OWN_D) ? ((cnt < MB) ? cnt + 4'd1 : MB) : 4'd1;
            end
        end
    end
    assign mem_ena  = c_gnt | d_gnt;
    assign mem_wea  = c_gnt ? c_we    : (d_gnt ? d_we    : 1'b0);
    assign mem_addr = c_gnt ? c_addr  : (d_gnt ? d_addr  : '0);
    assign mem_din  = c_gnt ? c_wdata : (d_gnt ? d_wdata : '0);
    // Tag pipe: stage 0 loads on the grant edge, last stage lines up with mem_dout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            tv    <= '0;
            tid   <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            tv[0]  <= mem_ena & ~mem_wea;
            tid[0] <= d_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                tv[i]  <= tv[i-1];
                tid[i] <= tid[i-1];
            end
        end
    end
    assign rv       = tv[RD_LAT-1];
    assign rid      = tid[RD_LAT-1];
    assign c_rvalid = rv & ~rid;
    assign d_rvalid = rv & rid;
    assign c_rdata  = c_rvalid ? mem_dout : '0;
    assign d_rdata  = d_rvalid ? mem_dout : '0;
    assign owner    = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, burst limit, read tagging and reset
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_ena, mem_wea;
    logic [1:0]  owner;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(2), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_ena(mem_ena), .mem_wea(mem_wea),
        .mem_dout(mem_dout), .owner(owner)
    );

    // Memory model: read-latency 2, preset contents plus written-word overlay
    logic [31:0] wmem [0:63];
    logic [63:0] wvld;
    logic [31:0] s1, s2;
    function automatic logic [31:0] init_val(input logic [5:0] a);
        case (a)
            6'h00:   return 32'h0000_0011;
            6'h04:   return 32'h0000_0022;
            6'h10:   return 32'hDEAD_BEEF;
            default: return 32'h0;
        endcase
    endfunction
    always @(posedge clk) begin
        if (!rst) begin
            wvld <= '0;
        end else if (mem_ena) begin
            if (mem_wea) begin
                wmem[mem_addr[5:0]] <= mem_din;
                wvld[mem_addr[5:0]] <= 1'b1;
            end
            s1 <= wvld[mem_addr[5:0]] ? wmem[mem_addr[5:0]] : init_val(mem_addr[5:0]);
        end
        s2 <= s1;
    end
    assign mem_dout = s2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        c_req = 1'b1; d_req = 1'b1; c_we = 1'b0; d_we = 1'b0;
        c_addr = '0; d_addr = '0; c_wdata = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cgnt", c_gnt, 0);
        chk("rst_dgnt", d_gnt, 0);
        chk("rst_ena", mem_ena, 0);
        chk("rst_wea", mem_wea, 0);
        chk("rst_owner", owner, 0);
        chk("rst_crvalid", c_rvalid, 0);
        // Release reset with both requesting (writes to scratch words)
        rst = 1'b1;
        c_we = 1'b1; d_we = 1'b1; c_addr = 32'h30; d_addr = 32'h34;
        #1;
        for (int i = 0; i < 10; i++) begin
            logic exp_c;
            exp_c = ((i / 4) % 2) == 0;
            chk("burst_cgnt", c_gnt, exp_c);
            chk("burst_dgnt", d_gnt, !exp_c);
            tick();
            chk("burst_owner", owner, exp_c ? 1 : 2);
        end
        c_req = 1'b0; d_req = 1'b0;
        #1;
        chk("idle_ena", mem_ena, 0);
        tick();
        chk("idle_owner", owner, 0);
        // C alone beyond the burst limit saturates cnt, so D wins as soon as it asks
        c_req = 1'b1;
        repeat (6) tick();
        d_req = 1'b1;
        #1;
        chk("sat_dgnt", d_gnt, 1);
        chk("sat_cgnt", c_gnt, 0);
        tick();
        chk("sat_owner", owner, 2);
        c_req = 1'b0; d_req = 1'b0;
        tick();
        // CPU-only reads of 0x10
        c_we = 1'b0; c_addr = 32'h10;
        for (int i = 0; i < 6; i++) begin
            logic v;
            c_req = (i < 3);
            v = (i >= 2) && (i <= 4);
            #1;
            chk("cpu_gnt", c_gnt, i < 3);
            chk("cpu_rvalid", c_rvalid, v);
            chk("cpu_rdata", c_rdata, v ? 32'hDEAD_BEEF : 32'h0);
            chk("cpu_drvalid", d_rvalid, 0);
            tick();
        end
        // Interleaved C then D reads
        c_req = 1'b1; c_addr = 32'h0;
        #1;
        chk("il_cgnt", c_gnt, 1);
        tick();
        c_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
        #1;
        chk("il_dgnt", d_gnt, 1);
        chk("il_early", c_rvalid, 0);
        tick();
        d_req = 1'b0;
        #1;
        chk("il_crvalid", c_rvalid, 1);
        chk("il_crdata", c_rdata, 32'h11);
        chk("il_drvalid0", d_rvalid, 0);
        tick();
        chk("il_drvalid", d_rvalid, 1);
        chk("il_drdata", d_rdata, 32'h22);
        chk("il_crvalid0", c_rvalid, 0);
        chk("il_crdata0", c_rdata, 0);
        tick();
        // D writes 0x8, then C reads it back
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hCAFE_0000;
        #1;
        chk("wr_dgnt", d_gnt, 1);
        chk("wr_wea", mem_wea, 1);
        chk("wr_addr", mem_addr, 32'h8);
        chk("wr_din", mem_din, 32'hCAFE_0000);
        tick();
        chk("wr_drvalid", d_rvalid, 0);
        d_req = 1'b0; c_req = 1'b1; c_we = 1'b0; c_addr = 32'h8;
        #1;
        chk("rd_cgnt", c_gnt, 1);
        chk("rd_wea", mem_wea, 0);
        tick();
        c_req = 1'b0;
        #1;
        chk("rd_ena", mem_ena, 0);
        tick();
        chk("rd_crvalid", c_rvalid, 1);
        chk("rd_crdata", c_rdata, 32'hCAFE_0000);
        chk("wr_no_drvalid", d_rvalid, 0);
        tick();
        // Reset while a read is in flight
        c_req = 1'b1; c_addr = 32'h10;
        #1;
        chk("mr_cgnt", c_gnt, 1);
        tick();
        c_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("mr_owner", owner, 0);
        chk("mr_rvalid", c_rvalid, 0);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_norvalid", c_rvalid, 0);
            chk("mr_rdata", c_rdata, 0);
        end
        chk("mr_owner_after", owner, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port instruction/data Memory between the multicycle CPU (requester C) and a debug/program-loader port (requester D). Grants one access per cycle using a round-robin policy with a burst limit. Tags in-flight reads so read data is returned only to the requester that issued the read. Sits between the CPU datapath's memory address/data mux and the Memory instance.

Parameters:
AW, 32, address width
DW, 32, data width
RD_LAT, 1, Memory read latency in cycles (legal 1..3)
MAX_BURST, 4, max consecutive grants to one owner while the other requester waits (legal 1..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
c_req  in  1  CPU access request
c_we  in  1  CPU write enable (0 = read)
c_addr  in  AW  CPU address
c_wdata  in  DW  CPU write data
c_gnt  out  1  CPU granted this cycle (combinational)
c_rvalid  out  1  CPU read data valid
c_rdata  out  DW  CPU read data
d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  debug port, same meaning as CPU
d_gnt, d_rvalid, d_rdata  out  1/1/DW  debug port, same meaning as CPU
mem_addr  out  AW  to Memory addra
mem_din  out  DW  to Memory dina
mem_ena  out  1  to Memory ena
mem_wea  out  1  to Memory wea
mem_dout  in  DW  from Memory douta
owner  out  2  registered state: 0 IDLE, 1 C, 2 D

Behaviour:
- State: owner {IDLE, C, D}, burst counter cnt (4 bits), read-tag pipe RD_LAT deep of {valid, id}.
- Reset (rst=0, async): owner=IDLE, cnt=0, tag pipe cleared. c_gnt=d_gnt=0, mem_ena=mem_wea=0, rvalid=0, rdata=0 while in reset. In-flight reads are dropped and never produce rvalid.
- Grant decision is combinational from owner, cnt, c_req, d_req. At most one grant per cycle:
  - No requests: no grant. Next owner=IDLE, cnt=0.
  - One request: grant it. cnt = min(cnt+1, MAX_BURST) if it is the current owner, else 1.
  - Both requests with owner=IDLE: grant C, cnt=1.
  - Both requests with owner=X and cnt<MAX_BURST: grant X, cnt+1.
  - Both requests with cnt==MAX_BURST: grant the other requester, cnt=1.
  - Next owner = granted requester.
- Granted cycle: mem_addr/mem_din/mem_wea come from the granted port; mem_ena=1. With no grant, mem_ena=0, mem_wea=0, mem_addr/mem_din=0.
- Handshake: requester holds req/we/addr/wdata stable until it samples gnt=1 at a rising edge. That edge completes the transfer. A requester may issue back-to-back requests.
- Write: takes effect on the grant edge. No rvalid is produced.
- Read: the grant pushes {1,id} into the tag pipe. Exactly RD_LAT cycles after the grant edge, that requester's rvalid=1 for one cycle, and its rdata=mem_dout. The other port's rdata=0. With rvalid=0, rdata=0.
- Pipelined reads: one outstanding per cycle, returned in grant order. Interleaved C/D reads return to the correct owners.
- Dropping req while not granted has no side effects.

Test Plan:
- Reset: hold rst=0 with c_req=d_req=1 -> c_gnt=d_gnt=0, mem_ena=0, owner=0. Release rst -> first cycle c_gnt=1, owner becomes 1.
- CPU only: c_req=1, c_we=0, addr 0x10 for 3 cycles, Memory word 0x10=0xDEADBEEF -> c_gnt=1 each cycle. c_rvalid=1 one cycle after each grant with c_rdata=0xDEADBEEF. d_rvalid stays 0.
- Burst limit (MAX_BURST=4): both req held continuously from IDLE -> grant sequence C,C,C,C,D,D,D,D,C... and cnt never exceeds 4.
- Interleaved reads (RD_LAT=2): C reads 0x0=0x11, D reads 0x4=0x22 on consecutive grants -> c_rvalid with 0x11 then d_rvalid with 0x22, two cycles after the respective grants.
- Write then read: D writes 0xCAFE0000 to 0x8, then C reads 0x8 -> mem_wea=1 only on the D grant cycle. c_rdata=0xCAFE0000.
- Reset mid-read: C read granted, rst pulsed low before RD_LAT elapses -> no c_rvalid. owner=0 after release.
